// File: rtl/ws2812_frame_tx_if.sv
// Frame/control bundle between the frame-building logic and the WS2812 transmitter.
// The master owns frame/start; the transmitter (slave) drives the line and status.
`timescale 1ns/1ps
interface ws2812_frame_tx_if #(
    parameter int NUM_LEDS = 64
);
    logic [NUM_LEDS*24-1:0] frame;
    logic                   start;
    logic                   dout;
    logic                   busy;
    logic                   done;

    modport master (
        output frame,
        output start,
        input  dout,
        input  busy,
        input  done
    );

    modport slave (
        input  frame,
        input  start,
        output dout,
        output busy,
        output done
    );
endinterface

// File: rtl/ws2812_frame_tx.sv
// Serialises one NUM_LEDS x 24-bit GRB frame onto a WS2812 data line, then holds
// the line low for the latch period and pulses done.
`timescale 1ns/1ps
module ws2812_frame_tx #(
    parameter int NUM_LEDS     = 64,
    parameter int T_BIT        = 125,
    parameter int T0H          = 40,
    parameter int T1H          = 80,
    parameter int RESET_CYCLES = 6000
) (
    input  logic              clk,
    input  logic              rst,
    ws2812_frame_tx_if.slave  bus
);
    localparam int NUM_BITS = NUM_LEDS * 24;
    localparam int CYC_MAX  = (T_BIT > RESET_CYCLES) ? T_BIT : RESET_CYCLES;
    localparam int BIT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int CYC_W    = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT       = BIT_W'(NUM_BITS - 1);
    localparam logic [CYC_W-1:0] BIT_LAST_CYC   = CYC_W'(T_BIT - 1);
    localparam logic [CYC_W-1:0] LATCH_LAST_CYC = CYC_W'(RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0] T0H_C          = CYC_W'(T0H);
    localparam logic [CYC_W-1:0] T1H_C          = CYC_W'(T1H);

    if (!(T0H > 0 && T0H < T1H && T1H < T_BIT && RESET_CYCLES >= 1 && NUM_LEDS >= 1)) begin : g_param_check
        $error("ws2812_frame_tx: illegal parameters (need 0 < T0H < T1H < T_BIT, RESET_CYCLES >= 1, NUM_LEDS >= 1)");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Shadow is stored in transmission order so global bit k sits at index k:
    // LED-major, G7 first within each LED. The permutation is pure wiring.
    logic [NUM_BITS-1:0] frame_tx_order;

    for (genvar k = 0; k < NUM_BITS; k++) begin : g_order
        assign frame_tx_order[k] = bus.frame[(k / 24) * 24 + 23 - (k % 24)];
    end

    state_t              state_q,   state_d;
    logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
    logic [CYC_W-1:0]    cyc_q,     cyc_d;
    logic [NUM_BITS-1:0] shadow_q,  shadow_d;
    logic                dout_q,    dout_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [CYC_W-1:0]    high_len;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        cyc_d     = cyc_q;
        shadow_d  = shadow_q;
        busy_d    = busy_q;
        dout_d    = 1'b0;
        done_d    = 1'b0;
        high_len  = shadow_q[bit_idx_q] ? T1H_C : T0H_C;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d   = SEND;
                    shadow_d  = frame_tx_order;
                    bit_idx_d = '0;
                    cyc_d     = '0;
                    busy_d    = 1'b1;
                    // Cycle 0 of any bit is high for both symbols (T0H > 0).
                    dout_d    = 1'b1;
                end
            end

            SEND: begin
                if (cyc_q == BIT_LAST_CYC) begin
                    cyc_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = LATCH;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        dout_d    = 1'b1;
                    end
                end else begin
                    cyc_d  = cyc_q + 1'b1;
                    dout_d = (cyc_d < high_len);
                end
            end

            LATCH: begin
                if (cyc_q == LATCH_LAST_CYC) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                bit_idx_d = '0;
                cyc_d     = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            cyc_q     <= '0;
            shadow_q  <= '0;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            cyc_q     <= cyc_d;
            shadow_q  <= shadow_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Self-checking bench for ws2812_frame_tx: random frames compared against a
// per-cycle waveform model derived from the bit-order and timing rules.
`timescale 1ns/1ps
module tb_ws2812_frame_tx;
    localparam int NL       = 2;
    localparam int FW       = NL * 24;
    localparam int NB       = NL * 24;
    localparam int T_BIT    = 125;
    localparam int T0H      = 40;
    localparam int T1H      = 80;
    localparam int RC       = 6000;
    localparam int SEND_CYC = NB * T_BIT;
    localparam int TOTAL    = SEND_CYC + RC + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ws2812_frame_tx_if #(.NUM_LEDS(NL)) bus ();

    ws2812_frame_tx #(
        .NUM_LEDS    (NL),
        .T_BIT       (T_BIT),
        .T0H         (T0H),
        .T1H         (T1H),
        .RESET_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Global bit k of a frame: LED k/24, MSB-first within the LED.
    function automatic logic model_bit(input logic [FW-1:0] f, input int k);
        return f[(k / 24) * 24 + 23 - (k % 24)];
    endfunction

    // Expected line level in SEND cycle t (t = 1 is the cycle after the accepting edge).
    function automatic logic model_dout(input logic [FW-1:0] f, input int t);
        int k;
        int c;
        k = (t - 1) / T_BIT;
        c = (t - 1) % T_BIT;
        return (c < (model_bit(f, k) ? T1H : T0H));
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < NL; i++) f[i*24 +: 24] = 24'($urandom());
        return f;
    endfunction

    // Starts a frame, then watches every cycle up to and including the done cycle.
    task automatic watch_frame(input logic [FW-1:0] exp, input string tag,
                               input bit disturb, input bit hold_start);
        int            wave_err;
        int            busy_err;
        int            done_err;
        int            first_bad;
        int            hi_cnt;
        int            bad_width;
        int            k;
        logic          exp_dout;
        logic          exp_busy;
        logic          exp_done;
        logic [FW-1:0] decoded;
        wave_err  = 0;
        busy_err  = 0;
        done_err  = 0;
        first_bad = -1;
        hi_cnt    = 0;
        bad_width = 0;
        decoded   = '0;

        @(negedge clk);
        bus.frame = exp;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = hold_start;

        for (int t = 1; t <= TOTAL; t++) begin
            @(negedge clk);
            exp_dout = (t <= SEND_CYC) ? model_dout(exp, t) : 1'b0;
            exp_busy = (t < TOTAL);
            exp_done = (t == TOTAL);
            if (bus.dout !== exp_dout) begin
                wave_err++;
                if (first_bad < 0) first_bad = t;
            end
            if (bus.busy !== exp_busy) busy_err++;
            if (bus.done !== exp_done) done_err++;
            if (t <= SEND_CYC) begin
                if (bus.dout === 1'b1) hi_cnt++;
                if ((t % T_BIT) == 0) begin
                    k = t / T_BIT - 1;
                    if (hi_cnt == T1H)      decoded[(k / 24) * 24 + 23 - (k % 24)] = 1'b1;
                    else if (hi_cnt != T0H) bad_width++;
                    hi_cnt = 0;
                end
            end
            if (disturb && t < SEND_CYC) begin
                if ((t % 100) == 0) begin
                    bus.start = 1'b1;
                    bus.frame = rand_frame();
                end else begin
                    bus.start = 1'b0;
                end
            end
        end

        checks++;
        if (wave_err !== 0) begin
            errors++;
            $display("FAIL %s waveform: actual=%0d wrong cycles (first at cycle %0d) required=0", tag, wave_err, first_bad);
        end
        checks++;
        if (decoded !== exp || bad_width !== 0) begin
            errors++;
            $display("FAIL %s decode: actual=%h (%0d bad pulse widths) required=%h", tag, decoded, bad_width, exp);
        end
        checks++;
        if (busy_err !== 0) begin
            errors++;
            $display("FAIL %s busy: actual=%0d wrong cycles required=0", tag, busy_err);
        end
        checks++;
        if (done_err !== 0) begin
            errors++;
            $display("FAIL %s done timing: actual=%0d wrong cycles required=0 (single pulse at cycle %0d)", tag, done_err, TOTAL);
        end

        @(negedge clk);
        checks++;
        if (hold_start) begin
            if ({bus.dout, bus.busy, bus.done} !== 3'b110) begin
                errors++;
                $display("FAIL %s next_frame_rise: actual dout/busy/done=%b required=110", tag, {bus.dout, bus.busy, bus.done});
            end
        end else if ({bus.dout, bus.busy, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL %s after_done: actual dout/busy/done=%b required=000", tag, {bus.dout, bus.busy, bus.done});
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.frame = '0;
        rst       = 1'b1;
        #12;
        checks++;
        if ({bus.dout, bus.busy, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: actual dout/busy/done=%b required=000", {bus.dout, bus.busy, bus.done});
        end
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        bus.frame = rand_frame();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.dout, bus.busy} !== 2'b11) begin
            errors++;
            $display("FAIL reset_pre_active: actual dout/busy=%b required=11", {bus.dout, bus.busy});
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.dout, bus.busy, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async: actual dout/busy/done=%b required=000", {bus.dout, bus.busy, bus.done});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.dout, bus.busy, bus.done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold_idle[%0d]: actual dout/busy/done=%b required=000", i, {bus.dout, bus.busy, bus.done});
            end
        end
    endtask

    task automatic test_zero_frame();
        watch_frame('0, "zero_frame", 1'b0, 1'b0);
    endtask

    task automatic test_pattern();
        logic [FW-1:0] f;
        f = {24'hFFFFFF, 24'h800001};
        watch_frame(f, "pattern", 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored_while_busy();
        watch_frame(rand_frame(), "start_while_busy", 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        logic [FW-1:0] f;
        int            stray;
        f     = rand_frame();
        stray = 0;
        @(negedge clk);
        bus.frame = f;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (30 * T_BIT + 10) @(negedge clk);
        checks++;
        if (bus.dout !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pre_high: actual dout=%b required=1", bus.dout);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.dout, bus.busy, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL midframe_reset_async: actual dout/busy/done=%b required=000", {bus.dout, bus.busy, bus.done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({bus.dout, bus.busy, bus.done} !== 3'b000) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midframe_no_done: actual=%0d active cycles after abort required=0", stray);
        end
        watch_frame(f, "restart_after_reset", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        watch_frame(rand_frame(), "back_to_back", 1'b0, 1'b1);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.frame = '0;
        test_reset();
        test_zero_frame();
        test_pattern();
        test_start_ignored_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
